// File: rtl/spu_pkg.sv
// Shared constants for the SPU global-buffer responder: default widths and
// the clear-FSM state encoding.
package spu_pkg;

  localparam int SPU_ADDR_WIDTH = 12;
  localparam int SPU_DATA_WIDTH = 32;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/spu_gbuf_mem_array.sv
// 1R1W synchronous storage array. A read and a write to the same address in
// one cycle return the pre-write word. Contents are never reset.
module spu_gbuf_mem_array
  import spu_pkg::*;
#(
  parameter int ADDR_WIDTH = SPU_ADDR_WIDTH,
  parameter int DATA_WIDTH = SPU_DATA_WIDTH,
  parameter int DEPTH      = 4096
) (
  input  logic                  core_clk,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Callers guarantee rd_addr/wr_addr < DEPTH whenever the enable is high.
  always_ff @(posedge core_clk) begin
    if (rd_en) rd_data_q <= mem_q[rd_addr];
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/spu_gbuf_responder.sv
// Global-buffer responder: fixed-latency pipelined reads, writes, range
// checking with a sticky error flag, and a zero-fill clear engine.
module spu_gbuf_responder
  import spu_pkg::*;
#(
  parameter int ADDR_WIDTH = SPU_ADDR_WIDTH,
  parameter int DATA_WIDTH = SPU_DATA_WIDTH,
  parameter int DEPTH      = 4096,
  parameter int RLATENCY   = 1
) (
  input  logic                  core_clk,
  input  logic                  rst_n,
  input  logic                  gbuf_ren,
  input  logic [ADDR_WIDTH-1:0] gbuf_raddr,
  output logic [DATA_WIDTH-1:0] gbuf_rdata,
  output logic                  gbuf_rvalid,
  input  logic                  gbuf_wen,
  input  logic [ADDR_WIDTH-1:0] gbuf_waddr,
  input  logic [DATA_WIDTH-1:0] gbuf_wdata,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_end,
  output logic                  addr_err,
  input  logic                  err_clr,
  output logic [0:0]            dbg_state
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_end_q, clr_end_d;
  logic                  addr_err_q, addr_err_d;
  logic [RLATENCY-1:0]   vld_q, vld_d;
  logic                  oob_q, oob_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic                  in_clear, rd_ok, wr_ok, rd_acc, wr_acc, err_set;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata, stage0_data, fresh_data;

  // Request handshake: there is no ready. A request is taken whenever its
  // enable is high in IDLE and silently dropped while the clear runs.
  assign in_clear = (state_q == ST_CLEAR);
  assign rd_ok    = ({1'b0, gbuf_raddr} < DEPTH_W);
  assign wr_ok    = ({1'b0, gbuf_waddr} < DEPTH_W);
  assign rd_acc   = gbuf_ren & ~in_clear;
  assign wr_acc   = gbuf_wen & ~in_clear;
  assign err_set  = (rd_acc & ~rd_ok) | (wr_acc & ~wr_ok);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_end_d = 1'b0;
    if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == LAST_ADDR) begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
        clr_end_d = 1'b1;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      end
    end else if (clr_start) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
    end
  end

  always_comb begin
    vld_d[0] = rd_acc;
    for (int i = 1; i < RLATENCY; i++) vld_d[i] = vld_q[i-1];
    oob_d      = rd_acc & ~rd_ok;
    addr_err_d = err_set | (addr_err_q & ~err_clr);
    hold_d     = gbuf_rdata;
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      clr_end_q  <= 1'b0;
      addr_err_q <= 1'b0;
      vld_q      <= '0;
      oob_q      <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_end_q  <= clr_end_d;
      addr_err_q <= addr_err_d;
      vld_q      <= vld_d;
      oob_q      <= oob_d;
      hold_q     <= hold_d;
    end
  end

  // The clear engine owns the write port for its whole run.
  assign mem_wen   = in_clear | (wr_acc & wr_ok);
  assign mem_waddr = in_clear ? clr_cnt_q : gbuf_waddr;
  assign mem_wdata = in_clear ? '0 : gbuf_wdata;

  spu_gbuf_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .core_clk (core_clk),
    .rd_en    (rd_acc & rd_ok),
    .rd_addr  (gbuf_raddr),
    .rd_data  (mem_rdata),
    .wr_en    (mem_wen),
    .wr_addr  (mem_waddr),
    .wr_data  (mem_wdata)
  );

  // The array's output register is the first latency stage.
  assign stage0_data = oob_q ? '0 : mem_rdata;

  if (RLATENCY == 1) begin : g_lat1
    assign fresh_data = stage0_data;
  end else begin : g_latn
    logic [DATA_WIDTH-1:0] dly_q [RLATENCY-1];
    logic [DATA_WIDTH-1:0] dly_d [RLATENCY-1];

    always_comb begin
      dly_d[0] = stage0_data;
      for (int i = 1; i < RLATENCY - 1; i++) dly_d[i] = dly_q[i-1];
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < RLATENCY - 1; i++) dly_q[i] <= '0;
      end else begin
        dly_q <= dly_d;
      end
    end

    assign fresh_data = dly_q[RLATENCY-2];
  end

  assign gbuf_rvalid = vld_q[RLATENCY-1];
  assign gbuf_rdata  = gbuf_rvalid ? fresh_data : hold_q;
  assign clr_busy    = in_clear;
  assign clr_end     = clr_end_q;
  assign addr_err    = addr_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spu_gbuf_responder.sv
// Directed bench for spu_gbuf_responder: a latency-1 and a latency-3 instance
// share every input and are checked against hand-computed expectations.
module tb_spu_gbuf_responder;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 3000;
  localparam logic [0:0] EXP_IDLE = 1'b0;

  logic          core_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ren, wen, clr_start, err_clr;
  logic [AW-1:0] raddr, waddr;
  logic [DW-1:0] wdata;

  logic [DW-1:0] rdata1, rdata3;
  logic          rvalid1, rvalid3, busy1, busy3, end1, end3, err1, err3;
  logic [0:0]    st1, st3;

  int total = 0;
  int bad   = 0;

  always #5 core_clk = ~core_clk;

  spu_gbuf_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RLATENCY(1)) u_l1 (
    .core_clk(core_clk), .rst_n(rst_n),
    .gbuf_ren(ren), .gbuf_raddr(raddr), .gbuf_rdata(rdata1), .gbuf_rvalid(rvalid1),
    .gbuf_wen(wen), .gbuf_waddr(waddr), .gbuf_wdata(wdata),
    .clr_start(clr_start), .clr_busy(busy1), .clr_end(end1),
    .addr_err(err1), .err_clr(err_clr), .dbg_state(st1)
  );

  spu_gbuf_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RLATENCY(3)) u_l3 (
    .core_clk(core_clk), .rst_n(rst_n),
    .gbuf_ren(ren), .gbuf_raddr(raddr), .gbuf_rdata(rdata3), .gbuf_rvalid(rvalid3),
    .gbuf_wen(wen), .gbuf_waddr(waddr), .gbuf_wdata(wdata),
    .clr_start(clr_start), .clr_busy(busy3), .clr_end(end3),
    .addr_err(err3), .err_clr(err_clr), .dbg_state(st3)
  );

  task automatic idle_inputs();
    ren = 1'b0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
    clr_start = 1'b0; err_clr = 1'b0;
  endtask

  task automatic tick();
    @(negedge core_clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({rvalid1, rvalid3, busy1, busy3, end1, end3, err1, err3} !== 8'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000000",
                      {rvalid1, rvalid3, busy1, busy3, end1, end3, err1, err3});
    end
    total++;
    if (rdata1 !== 32'h0 || rdata3 !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", rdata1, rdata3);
    end
    total++;
    if (st1 !== EXP_IDLE || st3 !== EXP_IDLE) begin
      bad++; $display("FAIL reset_state: got %b/%b want IDLE", st1, st3);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp3;
    tick(); wen = 1'b1; waddr = 12'h010; wdata = 32'hDEADBEEF;
    tick(); wen = 1'b0; ren = 1'b1; raddr = 12'h010;
    for (int c = 1; c <= 4; c++) begin
      tick(); ren = 1'b0;
      total++;
      if (rvalid1 !== 1'(c == 1)) begin
        bad++; $display("FAIL wr_rd_l1_valid c=%0d: got %b want %b", c, rvalid1, c == 1);
      end
      total++;
      if (rdata1 !== 32'hDEADBEEF) begin
        bad++; $display("FAIL wr_rd_l1_data c=%0d: got %h want deadbeef", c, rdata1);
      end
      total++;
      if (rvalid3 !== 1'(c == 3)) begin
        bad++; $display("FAIL wr_rd_l3_valid c=%0d: got %b want %b", c, rvalid3, c == 3);
      end
      exp3 = (c >= 3) ? 32'hDEADBEEF : 32'h0;
      total++;
      if (rdata3 !== exp3) begin
        bad++; $display("FAIL wr_rd_l3_data c=%0d: got %h want %h", c, rdata3, exp3);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e1, e3;
    for (int a = 0; a < 8; a++) begin
      tick(); wen = 1'b1; waddr = 12'(a); wdata = 32'(a);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      idle_inputs();
      e1 = (k >= 1 && k <= 8);
      e3 = (k >= 3 && k <= 10);
      total++;
      if (rvalid1 !== e1) begin
        bad++; $display("FAIL b2b_l1_valid k=%0d: got %b want %b", k, rvalid1, e1);
      end
      total++;
      if (rvalid3 !== e3) begin
        bad++; $display("FAIL b2b_l3_valid k=%0d: got %b want %b", k, rvalid3, e3);
      end
      if (e1) begin
        total++;
        if (rdata1 !== 32'(k - 1)) begin
          bad++; $display("FAIL b2b_l1_data k=%0d: got %h want %h", k, rdata1, 32'(k - 1));
        end
      end
      if (e3 || k == 11) begin
        total++;
        if (rdata3 !== 32'((k > 10) ? 7 : k - 3)) begin
          bad++; $display("FAIL b2b_l3_data k=%0d: got %h want %h", k, rdata3,
                          32'((k > 10) ? 7 : k - 3));
        end
      end
      if (k < 8) begin
        ren = 1'b1; raddr = 12'(k);
      end
    end
  endtask

  task automatic test_read_first();
    tick(); idle_inputs(); wen = 1'b1; waddr = 12'h020; wdata = 32'h11;
    tick(); ren = 1'b1; raddr = 12'h020; wdata = 32'h22;
    tick(); wen = 1'b0;
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h11) begin
      bad++; $display("FAIL rf_old_l1: got v=%b d=%h want v=1 d=00000011", rvalid1, rdata1);
    end
    tick(); ren = 1'b0;
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h22) begin
      bad++; $display("FAIL rf_new_l1: got v=%b d=%h want v=1 d=00000022", rvalid1, rdata1);
    end
    tick();
    total++;
    if (rvalid3 !== 1'b1 || rdata3 !== 32'h11) begin
      bad++; $display("FAIL rf_old_l3: got v=%b d=%h want v=1 d=00000011", rvalid3, rdata3);
    end
    tick();
    total++;
    if (rvalid3 !== 1'b1 || rdata3 !== 32'h22) begin
      bad++; $display("FAIL rf_new_l3: got v=%b d=%h want v=1 d=00000022", rvalid3, rdata3);
    end
    tick();
  endtask

  task automatic test_addr_err();
    idle_inputs(); wen = 1'b1; waddr = 12'h000; wdata = 32'h12345678;
    tick(); waddr = 12'hC00; wdata = 32'hCAFEF00D;
    tick(); wen = 1'b0; ren = 1'b1; raddr = 12'hC00;
    total++;
    if (err1 !== 1'b1 || err3 !== 1'b1) begin
      bad++; $display("FAIL err_on_write: got %b/%b want 1/1", err1, err3);
    end
    tick(); ren = 1'b0;
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h0) begin
      bad++; $display("FAIL oob_read_l1: got v=%b d=%h want v=1 d=0", rvalid1, rdata1);
    end
    repeat (2) tick();
    total++;
    if (rvalid3 !== 1'b1 || rdata3 !== 32'h0) begin
      bad++; $display("FAIL oob_read_l3: got v=%b d=%h want v=1 d=0", rvalid3, rdata3);
    end
    repeat (3) tick();
    total++;
    if (err1 !== 1'b1 || err3 !== 1'b1) begin
      bad++; $display("FAIL err_sticky: got %b/%b want 1/1", err1, err3);
    end
    err_clr = 1'b1; ren = 1'b1; raddr = 12'hFFF;
    tick(); err_clr = 1'b0; ren = 1'b0;
    total++;
    if (err1 !== 1'b1 || err3 !== 1'b1) begin
      bad++; $display("FAIL err_clr_vs_new: got %b/%b want 1/1", err1, err3);
    end
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    total++;
    if (err1 !== 1'b0 || err3 !== 1'b0) begin
      bad++; $display("FAIL err_clr: got %b/%b want 0/0", err1, err3);
    end
    ren = 1'b1; raddr = 12'h000;
    tick(); ren = 1'b0;
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h12345678) begin
      bad++; $display("FAIL mem0_untouched: got v=%b d=%h want v=1 d=12345678", rvalid1, rdata1);
    end
    wen = 1'b1; waddr = 12'hBB7; wdata = 32'h77;
    tick(); wen = 1'b0; ren = 1'b1; raddr = 12'hBB7;
    tick(); ren = 1'b0;
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h77 || err1 !== 1'b0) begin
      bad++; $display("FAIL last_addr: got v=%b d=%h e=%b want v=1 d=00000077 e=0",
                      rvalid1, rdata1, err1);
    end
    ren = 1'b1; raddr = 12'hBB8;
    tick(); ren = 1'b0;
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h0 || err1 !== 1'b1) begin
      bad++; $display("FAIL depth_addr: got v=%b d=%h e=%b want v=1 d=0 e=1",
                      rvalid1, rdata1, err1);
    end
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_clear();
    int busy1_n = 0, busy3_n = 0, end1_n = 0, end3_n = 0, end_at = 0;
    int rv1_n = 0, rv3_n = 0, err_n = 0;
    logic [AW-1:0] rb [7];
    for (int a = 0; a < DEPTH; a++) begin
      tick(); wen = 1'b1; waddr = 12'(a); wdata = 32'hFFFFFFFF;
    end
    tick(); idle_inputs(); clr_start = 1'b1; ren = 1'b1; raddr = 12'd5;
    for (int k = 1; k <= 3005; k++) begin
      tick();
      idle_inputs();
      if (busy1) busy1_n++;
      if (busy3) busy3_n++;
      if (end1) begin end1_n++; end_at = k; end
      if (end3) end3_n++;
      if (rvalid1) rv1_n++;
      if (rvalid3) rv3_n++;
      if (err1 || err3) err_n++;
      if (k == 1) begin
        total++;
        if (rvalid1 !== 1'b1 || rdata1 !== 32'hFFFFFFFF) begin
          bad++; $display("FAIL preclear_read_l1: got v=%b d=%h want v=1 d=ffffffff", rvalid1, rdata1);
        end
      end
      if (k == 3) begin
        total++;
        if (rvalid3 !== 1'b1 || rdata3 !== 32'hFFFFFFFF) begin
          bad++; $display("FAIL preclear_read_l3: got v=%b d=%h want v=1 d=ffffffff", rvalid3, rdata3);
        end
      end
      if (k == 50) clr_start = 1'b1;
      if (k == 60) begin wen = 1'b1; waddr = 12'd7; wdata = 32'h55; end
      if (k == 70) begin ren = 1'b1; raddr = 12'hC00; end
      if (k == 80) begin ren = 1'b1; raddr = 12'd3; end
    end
    total++;
    if (busy1_n != DEPTH || busy3_n != DEPTH) begin
      bad++; $display("FAIL clr_busy_cycles: got %0d/%0d want %0d", busy1_n, busy3_n, DEPTH);
    end
    total++;
    if (end1_n != 1 || end3_n != 1 || end_at != DEPTH + 1) begin
      bad++; $display("FAIL clr_end_pulse: got n=%0d/%0d at=%0d want n=1 at=%0d",
                      end1_n, end3_n, end_at, DEPTH + 1);
    end
    total++;
    if (rv1_n != 1 || rv3_n != 1 || err_n != 0) begin
      bad++; $display("FAIL clr_ignores_req: got rv=%0d/%0d err=%0d want 1/1/0", rv1_n, rv3_n, err_n);
    end
    rb = '{12'd0, 12'd1, 12'd3, 12'd5, 12'd7, 12'd1500, 12'd2999};
    for (int i = 0; i < 7; i++) begin
      ren = 1'b1; raddr = rb[i];
      tick(); ren = 1'b0;
      total++;
      if (rvalid1 !== 1'b1 || rdata1 !== 32'h0) begin
        bad++; $display("FAIL post_clear_read a=%0d: got v=%b d=%h want v=1 d=0", rb[i], rvalid1, rdata1);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_clear();
    int late_n = 0;
    idle_inputs(); clr_start = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick(); idle_inputs();
    end
    total++;
    if (busy1 !== 1'b1 || busy3 !== 1'b1) begin
      bad++; $display("FAIL busy_before_rst: got %b/%b want 1/1", busy1, busy3);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy1, busy3, end1, end3, rvalid1, rvalid3} !== 6'b0) begin
      bad++; $display("FAIL rst_mid_clear: got %b want 000000", {busy1, busy3, end1, end3, rvalid1, rvalid3});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (busy1 || busy3 || end1 || end3) late_n++;
    end
    total++;
    if (late_n != 0 || st1 !== EXP_IDLE || st3 !== EXP_IDLE) begin
      bad++; $display("FAIL after_rst_idle: got late=%0d st=%b/%b want 0 IDLE", late_n, st1, st3);
    end
    wen = 1'b1; waddr = 12'd5; wdata = 32'hABCD;
    tick(); wen = 1'b0; ren = 1'b1; raddr = 12'd5;
    tick(); ren = 1'b0;
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'hABCD) begin
      bad++; $display("FAIL pre_rst_read: got v=%b d=%h want v=1 d=0000abcd", rvalid1, rdata1);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (rvalid1 !== 1'b0 || rdata1 !== 32'h0 || rdata3 !== 32'h0) begin
      bad++; $display("FAIL rst_mid_read: got v=%b d=%h/%h want v=0 d=0/0", rvalid1, rdata1, rdata3);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    late_n = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rvalid1 || rvalid3) late_n++;
    end
    total++;
    if (late_n != 0) begin
      bad++; $display("FAIL no_rvalid_after_rst: got %0d want 0", late_n);
    end
    wen = 1'b1; waddr = 12'h010; wdata = 32'h600D;
    tick(); wen = 1'b0; ren = 1'b1; raddr = 12'h010;
    tick(); ren = 1'b0;
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h600D) begin
      bad++; $display("FAIL op_after_rst: got v=%b d=%h want v=1 d=0000600d", rvalid1, rdata1);
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_read_first();
    test_addr_err();
    test_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spu_gbuf_responder.md
SPU_GBUF_RESPONDER -- requirements
Module: spu_gbuf_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 12, read/write address width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, data word width.
REQ-003 SHALL have parameter DEPTH, 4096, number of storage words (DEPTH <= 2^ADDR_WIDTH).
REQ-004 SHALL have parameter RLATENCY, 1, read latency in cycles, legal range 1..3.
REQ-005 SHALL have port core_clk, input, 1, clock; reset rst_n, asynchronous, active-low; clock core_clk.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port gbuf_ren, input, 1, read request, one word per cycle.
REQ-008 SHALL have port gbuf_raddr, input, ADDR_WIDTH, read address, qualified by gbuf_ren.
REQ-009 SHALL have port gbuf_rdata, output, DATA_WIDTH, read data.
REQ-010 SHALL have port gbuf_rvalid, output, 1, rdata valid strobe.
REQ-011 SHALL have port gbuf_wen, input, 1, write request.
REQ-012 SHALL have ports gbuf_waddr, input, ADDR_WIDTH, and gbuf_wdata, input, DATA_WIDTH, qualified by gbuf_wen.
REQ-013 SHALL have ports clr_start, input, 1 (zero-fill start pulse); clr_busy, output, 1; clr_end, output, 1 (completion pulse).
REQ-014 SHALL have ports addr_err, output, 1 (sticky out-of-range flag) and err_clr, input, 1.

Function
REQ-015 Read: gbuf_ren at cycle T SHALL drive gbuf_rvalid=1 and gbuf_rdata=mem[raddr] at cycle T+RLATENCY; back-to-back reads fully pipelined, one result per cycle.
REQ-016 gbuf_rdata SHALL hold its last value while gbuf_rvalid=0.
REQ-017 Write: gbuf_wen at cycle T SHALL update mem[waddr] at the T clock edge; visible to reads issued at T+1 onward.
REQ-018 Same-cycle read and write to the same address SHALL return the old (pre-write) data (read-first).
REQ-019 Address >= DEPTH: write SHALL be dropped; read SHALL return rvalid with data 0; addr_err SHALL set the next cycle.
REQ-020 addr_err SHALL remain 1 until err_clr=1; err_clr coincident with a new error SHALL leave addr_err=1.
REQ-021 State machine: IDLE, CLEAR; clr_start in IDLE -> CLEAR; CLEAR writes 0 to addresses 0..DEPTH-1, one per cycle, then -> IDLE.
REQ-022 clr_busy SHALL be 1 exactly while in CLEAR (DEPTH cycles); clr_end SHALL pulse one cycle on the CLEAR->IDLE transition.
REQ-023 clr_start while in CLEAR SHALL be ignored; clear counter SHALL not restart.
REQ-024 gbuf_ren/gbuf_wen during CLEAR SHALL be ignored: no storage update, no rvalid, no addr_err.
REQ-025 Reads issued before CLEAR entry SHALL still complete with pre-clear data.

Reset
REQ-026 rst_n low SHALL force state IDLE, clear counter 0, gbuf_rvalid 0, gbuf_rdata 0, clr_busy 0, clr_end 0, addr_err 0, and flush the read pipeline.
REQ-027 Reset mid-CLEAR or mid-read SHALL abort without clr_end or rvalid; storage contents after reset SHALL be unspecified (not reset).

Structure
REQ-028 ADDR_WIDTH/DATA_WIDTH defaults and IDLE/CLEAR state encoding SHALL live in shared package spu_pkg.
REQ-029 Storage SHALL be a sub-module spu_gbuf_mem_array (1R1W, synchronous, read-first); FSM, latency pipeline and error logic in the top.

Verification
REQ-030 RLATENCY=1: write 0xDEADBEEF to 0x010, read 0x010 next cycle -> rvalid and 0xDEADBEEF exactly 1 cycle later.
REQ-031 RLATENCY=3: 8 back-to-back reads of 0x000..0x007 holding value=addr -> 8 consecutive rvalid cycles, data 0..7 in order, first 3 cycles after first ren.
REQ-032 mem[0x020]=0x11; same cycle ren/wen at 0x020 with wdata 0x22 -> rdata 0x11; subsequent read -> 0x22.
REQ-033 DEPTH=3000: write to 0xC00 then read 0xC00 -> rdata 0, addr_err=1 until err_clr; mem[0] untouched.
REQ-034 clr_start with prefilled 0xFFFFFFFF, second clr_start mid-clear, wen during clear -> clr_busy exactly DEPTH cycles, one clr_end, all reads after return 0.
REQ-035 Assert rst_n low at clear cycle 100 -> clr_busy/clr_end/rvalid 0 immediately; state IDLE after release.
